// File: rtl/bus_sram_responder.sv
// Word-addressed SRAM responder for the bus_start/bus_ready memory bus.
// Define BUS_RESP_WAIT_EN to insert WAIT_CYCLES wait states before each acknowledge.
module bus_sram_responder #(
  parameter int DEPTH_LOG2  = 12,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [29:0] bus_addr,
  input  logic        bus_start,
  input  logic        bus_write,
  input  logic [31:0] bus_data_wr,
  input  logic [3:0]  bus_data_be,
  output logic        bus_ready,
  output logic [31:0] bus_data_rd
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

`ifdef BUS_RESP_WAIT_EN
  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
`else
  localparam int UNUSED_WAIT_CYCLES = WAIT_CYCLES;
  typedef enum logic [1:0] {IDLE, RESP} state_t;
`endif

  state_t                r_state;
  state_t                w_next_state;
  logic                  r_ready;
  logic [31:0]           r_rdata;
  logic [31:0]           r_mem [DEPTH];
  logic                  w_accept;
  logic                  w_enter_resp;
  logic                  w_mem_we;
  logic [DEPTH_LOG2-1:0] w_acc_addr;
  logic                  w_acc_write;
  logic [31:0]           w_acc_wdata;
  logic [3:0]            w_acc_be;
  logic                  w_unused_addr;

  // Upper address bits alias onto the array.
  assign w_unused_addr = ^bus_addr[29:DEPTH_LOG2];

`ifdef BUS_RESP_WAIT_EN
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_next_cnt;
  logic [DEPTH_LOG2-1:0] r_addr;
  logic                  r_write;
  logic [31:0]           r_wdata;
  logic [3:0]            r_be;

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_addr  <= bus_addr[DEPTH_LOG2-1:0];
      r_write <= bus_write;
      r_wdata <= bus_data_wr;
      r_be    <= bus_data_be;
    end
  end

  // A zero-wait acceptance enters RESP on the same edge, so it uses the live request.
  assign w_acc_addr  = w_accept ? bus_addr[DEPTH_LOG2-1:0] : r_addr;
  assign w_acc_write = w_accept ? bus_write : r_write;
  assign w_acc_wdata = w_accept ? bus_data_wr : r_wdata;
  assign w_acc_be    = w_accept ? bus_data_be : r_be;
`else
  assign w_acc_addr  = bus_addr[DEPTH_LOG2-1:0];
  assign w_acc_write = bus_write;
  assign w_acc_wdata = bus_data_wr;
  assign w_acc_be    = bus_data_be;
`endif

  always_comb begin
    w_next_state = IDLE;
    w_accept     = 1'b0;
`ifdef BUS_RESP_WAIT_EN
    w_next_cnt   = r_cnt;
`endif
    case (r_state)
`ifdef BUS_RESP_WAIT_EN
      WAIT: begin
        if (r_cnt == '0) begin
          w_next_state = RESP;
        end else begin
          w_next_state = WAIT;
          w_next_cnt   = r_cnt - CNT_W'(1);
        end
      end
`endif
      default: begin
        if (bus_start) begin
          w_accept = 1'b1;
`ifdef BUS_RESP_WAIT_EN
          if (WAIT_CYCLES == 0) begin
            w_next_state = RESP;
          end else begin
            w_next_state = WAIT;
            w_next_cnt   = CNT_LOAD;
          end
`else
          w_next_state = RESP;
`endif
        end
      end
    endcase
  end

  assign w_enter_resp = (w_next_state == RESP);
  // An edge taken while reset is held must never touch the array.
  assign w_mem_we     = rst_n & w_enter_resp & w_acc_write;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ready <= 1'b0;
      r_rdata <= '0;
`ifdef BUS_RESP_WAIT_EN
      r_cnt   <= '0;
`endif
    end else begin
      r_state <= w_next_state;
      r_ready <= w_enter_resp;
`ifdef BUS_RESP_WAIT_EN
      r_cnt   <= w_next_cnt;
`endif
      if (w_enter_resp && !w_acc_write) begin
        r_rdata <= r_mem[w_acc_addr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_acc_be[i]) begin
          r_mem[w_acc_addr][8*i +: 8] <= w_acc_wdata[8*i +: 8];
        end
      end
    end
  end

  assign bus_ready   = r_ready;
  assign bus_data_rd = r_rdata;

endmodule

// File: tb/tb_bus_sram_responder.sv
// Directed and randomized bench for bus_sram_responder against a word-array reference model.
module tb_bus_sram_responder;
`ifdef BUS_RESP_WAIT_EN
  localparam int N = 2;
`else
  localparam int N = 0;
`endif

  typedef struct packed {
    logic        w;
    logic [29:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } op_t;

  logic        clk;
  logic        rst_n;
  logic [29:0] bus_addr;
  logic        bus_start;
  logic        bus_write;
  logic [31:0] bus_data_wr;
  logic [3:0]  bus_data_be;
  logic        bus_ready;
  logic [31:0] bus_data_rd;

  int          total = 0;
  int          bad = 0;
  logic [31:0] last_rd;
  logic [31:0] ref_mem [4096];
  bit          ref_known [4096];

  bus_sram_responder #(.DEPTH_LOG2(12), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus_addr(bus_addr), .bus_start(bus_start),
    .bus_write(bus_write), .bus_data_wr(bus_data_wr), .bus_data_be(bus_data_be),
    .bus_ready(bus_ready), .bus_data_rd(bus_data_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic op_t mk(input logic w, input logic [29:0] a, input logic [31:0] d,
                             input logic [3:0] be);
    op_t o;
    o.w = w; o.a = a; o.d = d; o.be = be;
    return o;
  endfunction

  function automatic int widx(input logic [29:0] a);
    return int'(a % 30'd4096);
  endfunction

  task automatic model_write(input op_t o);
    int k;
    k = widx(o.a);
    for (int b = 0; b < 4; b++)
      if (o.be[b]) ref_mem[k][8*b +: 8] = o.d[8*b +: 8];
    if (o.be == 4'hF) ref_known[k] = 1'b1;
  endtask

  task automatic drive(input op_t o);
    bus_start   = 1'b1;
    bus_write   = o.w;
    bus_addr    = o.a;
    bus_data_wr = o.d;
    bus_data_be = o.be;
  endtask

  // Issues ops back-to-back: each next start goes out in the acknowledge cycle of the previous.
  task automatic run_ops(input op_t ops[$]);
    int c;
    drive(ops[0]);
    for (int i = 0; i < ops.size(); i++) begin
      tick;
      bus_start = 1'b0;
      c = 1;
      while (!bus_ready && c < N + 6) begin
        tick;
        c++;
      end
      check("ack_latency", c, N + 1);
      if (ops[i].w) begin
        model_write(ops[i]);
      end else begin
        last_rd = bus_data_rd;
        if (ref_known[widx(ops[i].a)]) check("read_data", bus_data_rd, ref_mem[widx(ops[i].a)]);
      end
      if (i + 1 < ops.size()) drive(ops[i + 1]);
    end
    tick;
    check("ready_one_cycle", {31'd0, bus_ready}, 32'd0);
  endtask

  initial begin
    op_t q[$];
    int  nrdy;
    int  first;
    for (int i = 0; i < 4096; i++) ref_known[i] = 1'b0;
    rst_n = 1'b0;
    bus_start = 1'b1; bus_write = 1'b1; bus_addr = 30'h40;
    bus_data_wr = 32'h5555AAAA; bus_data_be = 4'hF;
    tick; tick;
    check("reset_ready", {31'd0, bus_ready}, 32'd0);
    check("reset_rdata", bus_data_rd, 32'd0);
    // Start held through the last reset edge must be dropped.
    rst_n = 1'b1;
    bus_start = 1'b0;
    for (int k = 0; k < N + 3; k++) begin
      check("release_no_ready", {31'd0, bus_ready}, 32'd0);
      tick;
    end

    // Preloaded read and its latency.
    q.delete();
    q.push_back(mk(1'b1, 30'h5, 32'hDEADBEEF, 4'hF));
    run_ops(q);
    q.delete();
    q.push_back(mk(1'b0, 30'h5, 32'h0, 4'h0));
    run_ops(q);
    check("preload_read", last_rd, 32'hDEADBEEF);

    // Byte-enable merge then back-to-back read-after-write.
    q.delete();
    q.push_back(mk(1'b1, 30'h10, 32'hAABBCCDD, 4'hF));
    run_ops(q);
    q.delete();
    q.push_back(mk(1'b1, 30'h10, 32'h11223344, 4'b0101));
    q.push_back(mk(1'b0, 30'h10, 32'h0, 4'hF));
    run_ops(q);
    check("be_merge_raw", last_rd, 32'hAA22CC44);

    // be=0 write is acknowledged and changes nothing.
    q.delete();
    q.push_back(mk(1'b1, 30'h10, 32'h0BADF00D, 4'b0000));
    q.push_back(mk(1'b0, 30'h10, 32'h0, 4'h0));
    run_ops(q);
    check("be_zero", last_rd, 32'hAA22CC44);

    // Aliasing of upper address bits.
    q.delete();
    q.push_back(mk(1'b1, 30'h1000, 32'h1, 4'hF));
    q.push_back(mk(1'b0, 30'h0, 32'h0, 4'h0));
    run_ops(q);
    check("alias_read", last_rd, 32'h1);

`ifdef BUS_RESP_WAIT_EN
    // A start presented during WAIT is ignored.
    q.delete();
    q.push_back(mk(1'b1, 30'h30, 32'h12345678, 4'hF));
    run_ops(q);
    drive(mk(1'b0, 30'h5, 32'h0, 4'h0));
    tick;
    drive(mk(1'b1, 30'h30, 32'hFFFFFFFF, 4'hF));
    tick;
    bus_start = 1'b0;
    nrdy = 0;
    first = 0;
    for (int k = 2; k < 10; k++) begin
      if (bus_ready) begin
        nrdy++;
        if (first == 0) begin
          first = k;
          check("wait_start_data", bus_data_rd, 32'hDEADBEEF);
        end
      end
      tick;
    end
    check("wait_start_count", nrdy, 1);
    check("wait_start_cycle", first, 3);
    q.delete();
    q.push_back(mk(1'b0, 30'h30, 32'h0, 4'h0));
    run_ops(q);
`endif

    // Reset mid-transaction drops the write.
    q.delete();
    q.push_back(mk(1'b1, 30'h20, 32'hAAAA5555, 4'hF));
    q.push_back(mk(1'b0, 30'h10, 32'h0, 4'h0));
    run_ops(q);
    drive(mk(1'b1, 30'h20, 32'hCAFEF00D, 4'hF));
    if (N == 0) rst_n = 1'b0;
    tick;
    bus_start = 1'b0;
    rst_n = 1'b0;
    tick; tick;
    check("midrst_rdata", bus_data_rd, 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < N + 4; k++) begin
      check("midrst_no_ready", {31'd0, bus_ready}, 32'd0);
      tick;
    end
    check("midrst_rdata_after", bus_data_rd, 32'd0);
    q.delete();
    q.push_back(mk(1'b0, 30'h20, 32'h0, 4'h0));
    run_ops(q);
    check("midrst_old_contents", last_rd, 32'hAAAA5555);

    // Fill a working window, then eight back-to-back reads.
    q.delete();
    for (int i = 0; i < 16; i++) q.push_back(mk(1'b1, 30'(12'h100 + i), $urandom, 4'hF));
    run_ops(q);
    q.delete();
    for (int i = 0; i < 8; i++) q.push_back(mk(1'b0, 30'(12'h100 + i), 32'h0, 4'h0));
    run_ops(q);

    // Randomized bursts with aliased addresses and random byte enables.
    for (int g = 0; g < 12; g++) begin
      q.delete();
      for (int i = 0; i < int'($urandom_range(1, 4)); i++)
        q.push_back(mk(1'($urandom), {18'($urandom), 12'(12'h100 + $urandom_range(0, 15))},
                       $urandom, 4'($urandom)));
      run_ops(q);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
